pool_window_gen: RTL and testbench

POOL_WINDOW_GEN -- requirements
Module: pool_window_gen

---
 rtl/pool_window_gen.sv | 154 +++++++++++++++
 tb/tb_pool_window_gen.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pool_window_gen.sv
`default_nettype none
// ============================================================================
// Module   : pool_window_gen
// Purpose  : Sliding R x C window generator for raster-order pixel streams.
//            It keeps the previous R-1 image rows in per-row line buffers and
//            the current neighbourhood in a window register. It emits one
//            flattened window for every STRIDE-aligned position. Both sides
//            use a valid/ready handshake.
// Ports    : clk        - sole clock, rising edge
//            rst        - synchronous active-high reset
//            in_valid   - in_data holds a pixel
//            in_ready   - a pixel is accepted this cycle if in_valid=1
//            in_data    - unsigned pixel, row-major raster order
//            out_valid  - out_win holds a complete window
//            out_ready  - downstream takes out_win this cycle
//            out_win    - element r*C+c at [(r*C+c)*In_d_W +: In_d_W];
//                         r=0 is the oldest row, c=0 the leftmost column
//            out_last   - out_win is the final window of the frame
// Revision : 1.0 - initial release
// ============================================================================
module pool_window_gen #(
  parameter int In_d_W = 8,
  parameter int R      = 3,
  parameter int C      = 3,
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int STRIDE = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [In_d_W-1:0]       in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [In_d_W*R*C-1:0]   out_win,
  output logic                    out_last
);

  localparam int c_XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int c_YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int c_SW = (STRIDE > 1) ? $clog2(STRIDE) : 1;

  localparam logic [c_XW-1:0] c_X_LAST = c_XW'(IMG_W - 1);
  localparam logic [c_YW-1:0] c_Y_LAST = c_YW'(IMG_H - 1);
  localparam logic [c_XW-1:0] c_X_FIRST_WIN = c_XW'(C - 1);
  localparam logic [c_YW-1:0] c_Y_FIRST_WIN = c_YW'(R - 1);
  localparam logic [c_SW-1:0] c_S_LAST = c_SW'(STRIDE - 1);

  logic [c_XW-1:0]   r_x, w_x_next;
  logic [c_YW-1:0]   r_y, w_y_next;
  // Stride phase counters hold (x-(C-1)) mod STRIDE and (y-(R-1)) mod STRIDE
  // once the position is past the first window; they stay 0 before that.
  logic [c_SW-1:0]   r_xph, w_xph_next;
  logic [c_SW-1:0]   r_yph, w_yph_next;
  logic              w_xfer, w_x_wrap, w_y_wrap, w_complete, w_is_last;
  logic [In_d_W-1:0] w_col [R];
  logic [In_d_W-1:0] r_win [R][C];

  assign in_ready   = !rst && (!out_valid || out_ready);
  assign w_xfer     = in_valid && in_ready;
  assign w_x_wrap   = (r_x == c_X_LAST);
  assign w_y_wrap   = (r_y == c_Y_LAST);
  assign w_is_last  = w_x_wrap && w_y_wrap;
  // Requiring x >= C-1 keeps columns from the previous row (wrap-around)
  // out of any emitted window; y >= R-1 does the same for the previous frame.
  assign w_complete = w_xfer && (r_x >= c_X_FIRST_WIN) && (r_y >= c_Y_FIRST_WIN)
                      && (r_xph == '0) && (r_yph == '0);

  always_comb begin
    w_x_next   = w_x_wrap ? '0 : r_x + 1'b1;
    w_xph_next = '0;
    if (w_x_next > c_X_FIRST_WIN) begin
      w_xph_next = (r_xph == c_S_LAST) ? '0 : r_xph + 1'b1;
    end
    w_y_next   = r_y;
    w_yph_next = r_yph;
    if (w_x_wrap) begin
      w_y_next   = w_y_wrap ? '0 : r_y + 1'b1;
      w_yph_next = '0;
      if (w_y_next > c_Y_FIRST_WIN) begin
        w_yph_next = (r_yph == c_S_LAST) ? '0 : r_yph + 1'b1;
      end
    end
  end

  // Line buffer i holds the row that is R-1-i rows older than the current
  // one. On each transfer the column at x moves one buffer older, so
  // w_col[0] is the oldest row and w_col[R-1] is the incoming pixel.
  generate
    if (R > 1) begin : g_lb
      for (genvar i = 0; i < R - 1; i++) begin : g_row
        logic [In_d_W-1:0] r_mem [IMG_W];
        assign w_col[i] = r_mem[r_x];
        always_ff @(posedge clk) begin
          if (w_xfer) begin
            r_mem[r_x] <= w_col[i+1];
          end
        end
      end
    end
  endgenerate

  assign w_col[R-1] = in_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_x       <= '0;
      r_y       <= '0;
      r_xph     <= '0;
      r_yph     <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      for (int r = 0; r < R; r++) begin
        for (int c = 0; c < C; c++) begin
          r_win[r][c] <= '0;
        end
      end
    end else begin
      if (w_xfer) begin
        r_x   <= w_x_next;
        r_y   <= w_y_next;
        r_xph <= w_xph_next;
        r_yph <= w_yph_next;
        for (int r = 0; r < R; r++) begin
          for (int c = 0; c < C - 1; c++) begin
            r_win[r][c] <= r_win[r][c+1];
          end
          r_win[r][C-1] <= w_col[r];
        end
      end
      // The window register doubles as the output register. While a window
      // is stalled, in_ready is low, so the register cannot shift under it.
      if (w_complete) begin
        out_valid <= 1'b1;
        out_last  <= w_is_last;
      end else if (out_ready) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

  always_comb begin
    out_win = '0;
    for (int r = 0; r < R; r++) begin
      for (int c = 0; c < C; c++) begin
        out_win[(r*C+c)*In_d_W +: In_d_W] = r_win[r][c];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pool_window_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_pool_window_gen
// Purpose  : Self-checking bench for pool_window_gen. Lane 0 is a 4x4 image
//            with stride 1. Lane 1 is a 5x5 image with stride 2. Both use
//            3x3 windows of 8-bit pixels. A reference model stores every
//            accepted pixel and queues the expected window. The monitor
//            compares each window against the queue when downstream accepts it.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pool_window_gen;

  localparam int c_N = 72;

  typedef struct packed {
    logic [c_N-1:0] win;
    logic           last;
  } exp_t;

  logic           clk = 1'b0;
  logic [1:0]     rst;
  logic [1:0]     in_valid;
  logic [1:0]     in_ready;
  logic [1:0]     out_valid;
  logic [1:0]     out_ready;
  logic [1:0]     out_last;
  logic [7:0]     in_data [2];
  logic [c_N-1:0] out_win [2];

  always #5 clk = ~clk;

  pool_window_gen #(.In_d_W(8), .R(3), .C(3), .IMG_W(4), .IMG_H(4), .STRIDE(1)) u_dut0 (
    .clk(clk), .rst(rst[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_data(in_data[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_win(out_win[0]), .out_last(out_last[0])
  );

  pool_window_gen #(.In_d_W(8), .R(3), .C(3), .IMG_W(5), .IMG_H(5), .STRIDE(2)) u_dut1 (
    .clk(clk), .rst(rst[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_data(in_data[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_win(out_win[1]), .out_last(out_last[1])
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [c_N-1:0] got, input logic [c_N-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Per-lane stimulus and model state
  int   img_w [2] = '{4, 5};
  int   strd  [2] = '{1, 2};
  int   pix_left [2], v_pct [2], r_pct [2], hold [2];
  int   px [2], py [2], fr [2], win_cnt [2], last_cnt [2];
  bit   rnd_data [2], hold_arm [2], hold_chk [2], acc [2];
  logic [7:0]     img [2][5][5];
  logic [c_N-1:0] got_log [2][16];
  logic [c_N-1:0] held_win [2];
  exp_t q0 [$];
  exp_t q1 [$];
  exp_t mon_e;

  function automatic int qsize(input int l);
    return (l == 0) ? q0.size() : q1.size();
  endfunction

  task automatic qpop(input int l, output exp_t e);
    if (l == 0) e = q0.pop_front();
    else        e = q1.pop_front();
  endtask

  // Window with top-left value b in an image whose pixel = b0 + w*y + x
  function automatic logic [c_N-1:0] win9(input int b, input int w);
    logic [c_N-1:0] v;
    v = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        v[(r*3+c)*8 +: 8] = 8'(b + r*w + c);
    return v;
  endfunction

  task automatic model_accept(input int l);
    exp_t e;
    int s;
    int w;
    s = strd[l];
    w = img_w[l];
    e = '0;
    img[l][py[l]][px[l]] = in_data[l];
    if (px[l] >= 2 && py[l] >= 2 && (px[l]-2) % s == 0 && (py[l]-2) % s == 0) begin
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          e.win[(r*3+c)*8 +: 8] = img[l][py[l]-2+r][px[l]-2+c];
      e.last = (px[l] == w-1) && (py[l] == w-1);
      if (l == 0) q0.push_back(e);
      else        q1.push_back(e);
    end
    if (px[l] == w-1) begin
      px[l] = 0;
      if (py[l] == w-1) begin
        py[l] = 0;
        fr[l]++;
      end else begin
        py[l]++;
      end
    end else begin
      px[l]++;
    end
    pix_left[l]--;
    acc[l] = 1;
  endtask

  // Monitor: outputs are sampled on the falling edge
  always @(negedge clk) begin
    for (int l = 0; l < 2; l++) begin
      if (!rst[l]) begin
        check("valid_vs_model", out_valid[l], qsize(l) != 0);
        if (hold_chk[l]) begin
          check("bp_in_ready", in_ready[l], 1'b0);
          check("bp_win_hold", out_win[l], held_win[l]);
        end
        if (out_valid[l] && out_ready[l] && qsize(l) != 0) begin
          qpop(l, mon_e);
          check("win", out_win[l], mon_e.win);
          check("last", out_last[l], mon_e.last);
          if (win_cnt[l] < 16) got_log[l][win_cnt[l]] = out_win[l];
          if (out_last[l]) last_cnt[l]++;
          win_cnt[l]++;
        end
        if (in_valid[l] && in_ready[l]) model_accept(l);
      end
    end
  end

  // Driver: inputs change 1 time unit after the rising edge
  always @(posedge clk) begin
    #1;
    for (int l = 0; l < 2; l++) begin
      hold_chk[l] = 0;
      if (hold_arm[l] && out_valid[l]) begin
        hold_arm[l] = 0;
        hold[l]     = 5;
        held_win[l] = out_win[l];
      end
      if (hold[l] > 0) begin
        out_ready[l] = 1'b0;
        hold[l]--;
        hold_chk[l] = 1;
      end else begin
        out_ready[l] = ($urandom_range(99) < r_pct[l]);
      end
      if (pix_left[l] > 0) begin
        in_valid[l] = ($urandom_range(99) < v_pct[l]);
        if (rnd_data[l]) begin
          if (acc[l]) in_data[l] = 8'($urandom);
        end else begin
          in_data[l] = 8'(fr[l]*100 + img_w[l]*py[l] + px[l]);
        end
      end else begin
        in_valid[l] = 1'b0;
      end
      acc[l] = 0;
    end
  end

  task automatic lane_reset(input int l);
    @(posedge clk);
    #2;
    rst[l] = 1'b1;
    if (l == 0) q0.delete();
    else        q1.delete();
    px[l] = 0; py[l] = 0; fr[l] = 0;
    win_cnt[l] = 0; last_cnt[l] = 0; pix_left[l] = 0; acc[l] = 1;
    @(negedge clk);
    check("rst_in_ready", in_ready[l], 1'b0);
    @(posedge clk);
    #2;
    rst[l] = 1'b0;
    @(negedge clk);
    #1;
    check("rst_out_valid", out_valid[l], 1'b0);
    check("rst_out_last", out_last[l], 1'b0);
    check("rst_out_win", out_win[l], '0);
  endtask

  task automatic wait_done(input int l, input int budget);
    int n;
    n = 0;
    while ((pix_left[l] > 0 || qsize(l) != 0) && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= budget) check("timeout", 1'b1, 1'b0);
  endtask

  initial begin
    rst = 2'b11;
    in_valid = 2'b00;
    out_ready = 2'b00;
    in_data[0] = 8'd0;
    in_data[1] = 8'd0;
    for (int l = 0; l < 2; l++) begin
      pix_left[l] = 0; v_pct[l] = 100; r_pct[l] = 100; hold[l] = 0;
      rnd_data[l] = 0; hold_arm[l] = 0; hold_chk[l] = 0; acc[l] = 1;
    end
    repeat (3) @(posedge clk);
    lane_reset(0);
    lane_reset(1);

    // Basic 4x4 stride-1 windowing
    pix_left[0] = 16;
    wait_done(0, 200);
    check("basic_count", 72'(win_cnt[0]), 72'd4);
    check("basic_first", got_log[0][0], win9(0, 4));
    check("basic_last_win", got_log[0][3], win9(5, 4));
    check("basic_last_cnt", 72'(last_cnt[0]), 72'd1);

    // Backpressure after the first window
    lane_reset(0);
    hold_arm[0] = 1;
    pix_left[0] = 16;
    wait_done(0, 200);
    check("bp_count", 72'(win_cnt[0]), 72'd4);
    check("bp_w0", got_log[0][0], win9(0, 4));
    check("bp_w1", got_log[0][1], win9(1, 4));
    check("bp_w2", got_log[0][2], win9(4, 4));
    check("bp_w3", got_log[0][3], win9(5, 4));

    // Stride 2 on 5x5
    pix_left[1] = 25;
    wait_done(1, 200);
    check("stride_count", 72'(win_cnt[1]), 72'd4);
    check("stride_tl0", 72'(got_log[1][0][7:0]), 72'd0);
    check("stride_tl1", 72'(got_log[1][1][7:0]), 72'd2);
    check("stride_tl2", 72'(got_log[1][2][7:0]), 72'd10);
    check("stride_tl3", 72'(got_log[1][3][7:0]), 72'd12);
    check("stride_last_cnt", 72'(last_cnt[1]), 72'd1);

    // Two back-to-back frames, second frame offset by 100
    lane_reset(0);
    pix_left[0] = 32;
    wait_done(0, 300);
    check("b2b_count", 72'(win_cnt[0]), 72'd8);
    check("b2b_w4", got_log[0][4], win9(100, 4));
    check("b2b_w7", got_log[0][7], win9(105, 4));
    check("b2b_last_cnt", 72'(last_cnt[0]), 72'd2);

    // Reset after pixel 9, then a fresh frame
    lane_reset(0);
    pix_left[0] = 10;
    wait_done(0, 200);
    lane_reset(0);
    pix_left[0] = 16;
    wait_done(0, 200);
    check("mid_rst_count", 72'(win_cnt[0]), 72'd4);
    check("mid_rst_first", got_log[0][0], win9(0, 4));
    check("mid_rst_last", got_log[0][3], win9(5, 4));

    // Random throttling, random data, 20 frames on both lanes
    lane_reset(0);
    lane_reset(1);
    for (int l = 0; l < 2; l++) begin
      rnd_data[l] = 1; v_pct[l] = 50; r_pct[l] = 50;
    end
    pix_left[0] = 20 * 16;
    pix_left[1] = 20 * 25;
    wait_done(0, 20000);
    wait_done(1, 20000);
    check("rand_count0", 72'(win_cnt[0]), 72'd80);
    check("rand_count1", 72'(win_cnt[1]), 72'd80);
    check("rand_last0", 72'(last_cnt[0]), 72'd20);
    check("rand_last1", 72'(last_cnt[1]), 72'd20);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
